// File: rtl/alu_share_arbiter_if.sv
// Request/response channels and ALU operand bus of the shared-ALU arbiter.
// Handshake rule for every valid/ready pair: a transfer happens on a rising edge where both are high.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_opcode;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_opcode;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_data,
    output alu_opcode, alu_a, alu_b,
    input  alu_out
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  alu_opcode, alu_a, alu_b,
    output alu_out
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two request channels.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until consumed).
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic [CNTW-1:0]     ops_done,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;

  logic             grant;
  logic             req_any;
  logic             req0_ready;
  logic             req1_ready;
  logic             owner_rsp_ready;

  // Contention goes to the channel that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req_any         = bus.req0_valid | bus.req1_valid;
  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    ops_done_d   = ops_done_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // The granted channel is always valid, so ready here means handshake.
        if (req_any) begin
          req0_ready   = ~grant & rst_n;
          req1_ready   = grant & rst_n;
          owner_d      = grant;
          last_grant_d = grant;
          alu_opcode_d = grant ? bus.req1_opcode : bus.req0_opcode;
          alu_a_d      = grant ? bus.req1_a      : bus.req0_a;
          alu_b_d      = grant ? bus.req1_b      : bus.req0_b;
          state_d      = EXEC;
        end
      end

      EXEC: begin
        if (owner_q) begin
          rsp1_data_d  = bus.alu_out;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_data_d  = bus.alu_out;
          rsp0_valid_d = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          ops_done_d   = ops_done_q + CNT_ONE;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;

  assign busy        = (state_q != IDLE);
  assign ops_done    = ops_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed sequences, a vector table and random traffic,
// all cross-checked by a cycle-level reference model of the two-channel arbiter.
module tb_alu_share_arbiter;

  localparam int WIDTH = 8;
  localparam int OPW   = 2;
  localparam int CNTW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            busy;
  logic [CNTW-1:0] ops_done;
  logic [1:0]      dbg_state;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus();

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .ops_done    (ops_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_model(input logic [OPW-1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  assign bus.alu_out = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit ch, input bit v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
    if (ch) begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic idle_inputs();
    drive_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
    drive_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin tick(); n++; end
    chk("idle_wait", busy, 0);
  endtask

  // Issue one op on a channel and collect its result (rsp_ready assumed high).
  task automatic do_op(input bit ch, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, output logic [7:0] data);
    int n;
    drive_req(ch, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!(ch ? bus.req1_ready : bus.req0_ready) && n < 20) begin tick(); n++; end
    chk("grant_wait", ch ? bus.req1_ready : bus.req0_ready, 1);
    tick();
    drive_req(ch, 1'b0, op, a, b);
    n = 0;
    while (!(ch ? bus.rsp1_valid : bus.rsp0_valid) && n < 20) begin tick(); n++; end
    chk("rsp_wait", ch ? bus.rsp1_valid : bus.rsp0_valid, 1);
    data = ch ? bus.rsp1_data : bus.rsp0_data;
    tick();
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  int               grant_ch_q[$];
  int               grant_cyc_q[$];
  int               cyc     = 0;
  bit               m_idle  = 1'b1;
  bit               m_last  = 1'b1;
  bit               m_owner = 1'b0;
  int               m_age   = 0;
  logic [CNTW-1:0]  m_ops   = '0;
  bit               e_r0, e_r1, e_v0, e_v1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_idle = 1'b1; m_last = 1'b1; m_owner = 1'b0; m_age = 0; m_ops = '0;
      exp_q0.delete(); exp_q1.delete();
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    end else begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (m_idle) begin
        if (bus.req0_valid && bus.req1_valid) begin
          e_r0 = m_last;
          e_r1 = !m_last;
        end else begin
          e_r0 = bus.req0_valid;
          e_r1 = bus.req1_valid;
        end
      end
      e_v0 = !m_idle && !m_owner && (m_age >= 1);
      e_v1 = !m_idle &&  m_owner && (m_age >= 1);
      chk("req0_ready", bus.req0_ready, e_r0);
      chk("req1_ready", bus.req1_ready, e_r1);
      chk("busy", busy, !m_idle);
      chk("ops_done", ops_done, m_ops);
      chk("rsp0_valid", bus.rsp0_valid, e_v0);
      chk("rsp1_valid", bus.rsp1_valid, e_v1);
      if (e_v0 && exp_q0.size() > 0) chk("rsp0_data", bus.rsp0_data, exp_q0[0]);
      if (e_v1 && exp_q1.size() > 0) chk("rsp1_data", bus.rsp1_data, exp_q1[0]);

      if (!m_idle) begin
        if (m_age >= 1 && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
          if (m_owner && exp_q1.size() > 0) void'(exp_q1.pop_front());
          if (!m_owner && exp_q0.size() > 0) void'(exp_q0.pop_front());
          m_ops++;
          m_idle = 1'b1;
          m_age  = 0;
        end else begin
          m_age++;
        end
      end else if (e_r0 || e_r1) begin
        m_owner = e_r1;
        m_last  = e_r1;
        m_idle  = 1'b0;
        m_age   = 0;
        if (e_r1) exp_q1.push_back(alu_model(bus.req1_opcode, bus.req1_a, bus.req1_b));
        else      exp_q0.push_back(alu_model(bus.req0_opcode, bus.req0_a, bus.req0_b));
        grant_ch_q.push_back(int'(e_r1));
        grant_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit         ch;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] d;
    int         start;
    int         n;

    vecs[0] = '{1'b0, 2'd0, 8'd3,    8'd2,    8'd5};
    vecs[1] = '{1'b1, 2'd1, 8'd7,    8'd2,    8'd5};
    vecs[2] = '{1'b0, 2'd2, 8'd6,    8'd2,    8'd2};
    vecs[3] = '{1'b1, 2'd3, 8'd6,    8'd2,    8'd6};
    vecs[4] = '{1'b0, 2'd0, 8'd200,  8'd100,  8'd44};
    vecs[5] = '{1'b1, 2'd1, 8'd2,    8'd5,    8'd253};
    vecs[6] = '{1'b0, 2'd2, 8'hF0,   8'h3C,   8'h30};
    vecs[7] = '{1'b1, 2'd3, 8'hF0,   8'h0F,   8'hFF};

    // Reset values, with a request pending to show ready stays low in reset.
    rst_n = 1'b0;
    idle_inputs();
    bus.req0_valid = 1'b1;
    repeat (2) tick();
    chk("reset_req0_ready", bus.req0_ready, 0);
    chk("reset_alu_a", bus.alu_a, 0);
    chk("reset_alu_op", bus.alu_opcode, 0);
    chk("reset_rsp0_data", bus.rsp0_data, 0);
    chk("reset_ops_done", ops_done, 0);
    chk("reset_state", dbg_state, 0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single channel-0 add with latency and hold.
    bus.rsp0_ready = 1'b0;
    drive_req(1'b0, 1'b1, 2'd0, 8'd3, 8'd2);
    #1;
    chk("t1_req0_ready", bus.req0_ready, 1);
    chk("t1_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_rsp0_valid", bus.rsp0_valid, 0);
    chk("t1_alu_a", bus.alu_a, 3);
    chk("t1_alu_b", bus.alu_b, 2);
    tick();
    chk("t1_rsp0_valid", bus.rsp0_valid, 1);
    chk("t1_rsp0_data", bus.rsp0_data, 5);
    chk("t1_rsp1_valid", bus.rsp1_valid, 0);
    tick();
    chk("t1_hold_valid", bus.rsp0_valid, 1);
    chk("t1_hold_ops", ops_done, 0);
    bus.rsp0_ready = 1'b1;
    tick();
    chk("t1_done_valid", bus.rsp0_valid, 0);
    chk("t1_done_ops", ops_done, 1);
    chk("t1_done_busy", busy, 0);

    // First contention after reset: channel 0 wins, channel 1 follows.
    reset_dut();
    drive_req(1'b0, 1'b1, 2'd1, 8'd7, 8'd2);
    drive_req(1'b1, 1'b1, 2'd2, 8'd6, 8'd2);
    #1;
    chk("t2_req0_ready", bus.req0_ready, 1);
    chk("t2_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("t2_rsp0_data", bus.rsp0_data, 5);
    tick();
    chk("t2_req1_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("t2_rsp1_data", bus.rsp1_data, 2);
    tick();
    chk("t2_ops_done", ops_done, 2);

    // Continuous contention: six grants alternating, three cycles apart.
    start = grant_ch_q.size();
    drive_req(1'b0, 1'b1, 2'd0, 8'd9, 8'd4);
    drive_req(1'b1, 1'b1, 2'd3, 8'd6, 8'd2);
    n = 0;
    while (grant_ch_q.size() < start + 6 && n < 60) begin tick(); n++; end
    drive_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
    drive_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
    chk("t3_grant_count", grant_ch_q.size() - start, 6);
    if (grant_ch_q.size() >= start + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t3_grant_order", grant_ch_q[start + k], k % 2);
        if (k > 0) chk("t3_grant_spacing", grant_cyc_q[start + k] - grant_cyc_q[start + k - 1], 3);
      end
    end
    wait_idle();

    // Backpressure on channel 1 while channel 0 waits.
    drive_req(1'b1, 1'b1, 2'd3, 8'd6, 8'd2);
    bus.rsp1_ready = 1'b0;
    tick();
    bus.req1_valid = 1'b0;
    drive_req(1'b0, 1'b1, 2'd0, 8'd1, 8'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_data", bus.rsp1_data, 6);
      chk("t4_stall_valid", bus.rsp1_valid, 1);
      chk("t4_stall_req0_ready", bus.req0_ready, 0);
      chk("t4_stall_req1_ready", bus.req1_ready, 0);
      chk("t4_stall_busy", busy, 1);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    chk("t4_release_busy", busy, 0);
    chk("t4_release_req0_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    wait_idle();

    // Reset while a channel-0 result is held.
    bus.rsp0_ready = 1'b0;
    drive_req(1'b0, 1'b1, 2'd0, 8'd4, 8'd4);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("t5_pre_valid", bus.rsp0_valid, 1);
    chk("t5_pre_ops", ops_done, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bus.rsp0_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ops", ops_done, 0);
    chk("t5_async_alu_a", bus.alu_a, 0);
    chk("t5_async_data", bus.rsp0_data, 0);
    tick();
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    drive_req(1'b0, 1'b1, 2'd0, 8'd1, 8'd2);
    drive_req(1'b1, 1'b1, 2'd0, 8'd3, 8'd4);
    #1;
    chk("t5_first_req0_ready", bus.req0_ready, 1);
    chk("t5_first_req1_ready", bus.req1_ready, 0);
    drive_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
    drive_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
    tick();
    chk("t5_cancel_busy", busy, 0);

    // Vector table; the counter wraps 1,2,3,0,1,... with a 2-bit width.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].ch, vecs[i].op, vecs[i].a, vecs[i].b, d);
      chk("vec_data", d, vecs[i].exp);
      chk("vec_ops_done", ops_done, (i + 1) % 4);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      bus.req0_valid  = ($urandom_range(0, 99) < 60);
      bus.req0_opcode = 2'($urandom_range(0, 3));
      bus.req0_a      = 8'($urandom_range(0, 255));
      bus.req0_b      = 8'($urandom_range(0, 255));
      bus.req1_valid  = ($urandom_range(0, 99) < 60);
      bus.req1_opcode = 2'($urandom_range(0, 3));
      bus.req1_a      = 8'($urandom_range(0, 255));
      bus.req1_b      = 8'($urandom_range(0, 255));
      bus.rsp0_ready  = ($urandom_range(0, 99) < 70);
      bus.rsp1_ready  = ($urandom_range(0, 99) < 70);
      tick();
    end
    idle_inputs();
    wait_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
